// File: rtl/cnn_ctrl_regfile_if.sv
// Host memory-mapped port of the CNN control register file.
// Byte enables select write lanes; an all-zero we means read.
interface cnnip_mem_if #(
  parameter int ADDR_W = 4
);
  logic              en;
  logic [3:0]        we;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       din;
  logic [31:0]       dout;
  logic              valid;

  modport master (
    output en, we, addr, din,
    input  dout, valid
  );

  modport slave (
    input  en, we, addr, din,
    output dout, valid
  );
endinterface

// File: rtl/cnn_ctrl_regfile.sv
// CNN accelerator control/status register file with command FSM,
// W1C status flags, busy-cycle counter and byte-enabled config bank.
module cnn_ctrl_regfile #(
  parameter int NUM_CFG = 8,
  parameter int ADDR_W  = 4
) (
  input  logic                  clk_a,
  input  logic                  arstz_aq,
  cnnip_mem_if.slave            mem_if,
  input  logic                  CMD_DONE,
  input  logic                  CMD_DONE_VALID,
  output logic                  CMD_START,
  output logic                  CMD_BUSY,
  output logic                  IRQ,
  output logic [NUM_CFG*32-1:0] CFG_REGS
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CNT  = ADDR_W'(2);

  state_t state_q, state_d;

  logic [NUM_CFG-1:0][31:0] cfg;
  logic [31:0]       cnt;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] idx;
  logic irq_en, done, err, start_ign;
  logic wr, rd, ctrl_wr, stat_w1c;
  logic start_req, start_ok, start_rej, done_evt;
  logic unused_addr;

  assign idx         = mem_if.addr[ADDR_W+1:2];
  assign unused_addr = ^mem_if.addr[1:0];
  assign wr          = mem_if.en & (|mem_if.we);
  assign rd          = mem_if.en & ~(|mem_if.we);
  assign ctrl_wr     = wr & mem_if.we[0] & (idx == A_CTRL);
  assign stat_w1c    = wr & mem_if.we[0] & (idx == A_STAT);
  assign start_req   = ctrl_wr & mem_if.din[0];

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Completion has priority: a start seen while BUSY is always rejected.
  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_rej = 1'b0;
    done_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          start_ok = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        start_rej = start_req;
        if (CMD_DONE_VALID) begin
          done_evt = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hardware sets are written last so they win over a same-edge W1C.
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      irq_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      start_ign <= 1'b0;
      cnt       <= '0;
      CMD_START <= 1'b0;
    end else begin
      CMD_START <= start_ok;
      if (ctrl_wr) irq_en <= mem_if.din[1];
      if (start_ok) begin
        done <= 1'b0;
        err  <= 1'b0;
      end else begin
        if (stat_w1c && mem_if.din[1]) done <= 1'b0;
        if (stat_w1c && mem_if.din[2]) err  <= 1'b0;
        if (done_evt) begin
          if (CMD_DONE) done <= 1'b1;
          else          err  <= 1'b1;
        end
      end
      if (stat_w1c && mem_if.din[3]) start_ign <= 1'b0;
      if (start_rej) start_ign <= 1'b1;
      if (start_ok) cnt <= '0;
      else if (state_q == BUSY && cnt != '1) cnt <= cnt + 32'd1;
    end
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      cfg <= '0;
    end else begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (wr && idx == ADDR_W'(i + 4)) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_if.we[b]) cfg[i][8*b +: 8] <= mem_if.din[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      A_CTRL:  rdata = {30'b0, irq_en, 1'b0};
      A_STAT:  rdata = {28'b0, start_ign, err, done, state_q == BUSY};
      A_CNT:   rdata = cnt;
      default: begin
        for (int i = 0; i < NUM_CFG; i++) begin
          if (idx == ADDR_W'(i + 4)) rdata = cfg[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      mem_if.dout  <= '0;
      mem_if.valid <= 1'b0;
    end else begin
      mem_if.valid <= rd;
      if (rd) mem_if.dout <= rdata;
    end
  end

  assign CMD_BUSY = (state_q == BUSY);
  assign IRQ      = irq_en & (done | err);
  assign CFG_REGS = cfg;

endmodule

// File: tb/tb_cnn_ctrl_regfile.sv
// Bench for cnn_ctrl_regfile: vector table, directed command
// sequences, then random traffic against a reference model.
module tb_cnn_ctrl_regfile;

  logic clk_a = 1'b0;
  logic arstz_aq;
  logic cmd_done, cmd_done_valid;
  wire  cmd_start, cmd_busy, irq;
  wire  [255:0] cfg_regs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_a = ~clk_a;

  cnnip_mem_if #(.ADDR_W(4)) mif();

  cnn_ctrl_regfile #(.NUM_CFG(8), .ADDR_W(4)) dut (
    .clk_a          (clk_a),
    .arstz_aq       (arstz_aq),
    .mem_if         (mif),
    .CMD_DONE       (cmd_done),
    .CMD_DONE_VALID (cmd_done_valid),
    .CMD_START      (cmd_start),
    .CMD_BUSY       (cmd_busy),
    .IRQ            (irq),
    .CFG_REGS       (cfg_regs)
  );

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [5:0]  addr;
    logic [31:0] din;
    logic        exp_valid;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] we,
                       input logic [5:0] addr, input logic [31:0] din);
    mif.en   = en;
    mif.we   = we;
    mif.addr = addr;
    mif.din  = din;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 6'h0, 32'h0);
    cmd_done_valid = 1'b0;
    cmd_done       = 1'b0;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [3:0] we,
                    input logic [31:0] din);
    drive(1'b1, we, addr, din);
    tick();
    drive(1'b0, 4'h0, 6'h0, 32'h0);
  endtask

  task automatic rd_chk(input string nm, input logic [5:0] addr,
                        input logic [31:0] exp);
    drive(1'b1, 4'h0, addr, 32'h0);
    tick();
    drive(1'b0, 4'h0, 6'h0, 32'h0);
    chk({nm, "_valid"}, {31'b0, mif.valid}, 32'd1);
    chk(nm, mif.dout, exp);
  endtask

  // Reference model: command tracked by the edge it started on.
  bit          m_busy, m_done, m_err, m_ign, m_irq_en;
  longint      m_edge, m_start_edge;
  logic [31:0] m_frozen;
  logic [31:0] m_cfg[8];

  function automatic logic [31:0] m_cnt();
    longint d;
    if (!m_busy) return m_frozen;
    d = m_edge - m_start_edge;
    if (d > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return d[31:0];
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    if (idx == 0) return {30'b0, m_irq_en, 1'b0};
    if (idx == 1) return {28'b0, m_ign, m_err, m_done, m_busy};
    if (idx == 2) return m_cnt();
    if (idx >= 4 && idx < 12) return m_cfg[idx-4];
    return 32'h0;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_ign = 0; m_irq_en = 0;
    m_edge = 0; m_start_edge = 0; m_frozen = '0;
    for (int i = 0; i < 8; i++) m_cfg[i] = '0;
  endtask

  task automatic m_step(input logic en, input logic [3:0] we,
                        input logic [5:0] addr, input logic [31:0] din,
                        input logic dv, input logic dn,
                        output logic e_valid, output logic [31:0] e_dout,
                        output logic e_start);
    int  idx;
    bit  is_wr, start;
    idx     = int'(addr[5:2]);
    is_wr   = en && (we != 0);
    e_valid = en && (we == 0);
    e_dout  = m_read(idx);
    start   = is_wr && we[0] && idx == 0 && din[0];
    e_start = start && !m_busy;
    if (is_wr && we[0] && idx == 1) begin
      if (din[1]) m_done = 0;
      if (din[2]) m_err  = 0;
      if (din[3]) m_ign  = 0;
    end
    if (is_wr && we[0] && idx == 0) m_irq_en = din[1];
    if (is_wr && idx >= 4 && idx < 12) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) m_cfg[idx-4][8*b +: 8] = din[8*b +: 8];
    end
    if (m_busy) begin
      if (start) m_ign = 1;
      if (dv) begin
        m_frozen = m_edge + 1 - m_start_edge > 64'hFFFF_FFFF ?
                   32'hFFFF_FFFF : 32'(m_edge + 1 - m_start_edge);
        m_busy = 0;
        if (dn) m_done = 1;
        else    m_err  = 1;
      end
    end else if (start) begin
      m_busy = 1;
      m_done = 0;
      m_err  = 0;
      m_start_edge = m_edge + 1;
    end
    m_edge++;
  endtask

  initial begin
    logic        e_valid, e_start, r_en, r_dv, r_dn;
    logic [31:0] e_dout, r_din;
    logic [3:0]  r_we;
    logic [5:0]  r_addr;
    logic [255:0] e_cfg;

    arstz_aq = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_start", {31'b0, cmd_start}, 32'd0);
    chk("rst_busy",  {31'b0, cmd_busy},  32'd0);
    chk("rst_irq",   {31'b0, irq},       32'd0);
    chk("rst_valid", {31'b0, mif.valid}, 32'd0);
    chk("rst_dout",  mif.dout,           32'd0);
    chk("rst_cfg",   cfg_regs[31:0] | cfg_regs[255:224], 32'd0);
    arstz_aq = 1'b1;
    tick();

    for (int i = 0; i < 4; i++)
      vt[i] = '{1'b1, 4'h0, 6'(4*i), 32'h0, 1'b1, 32'h0};
    for (int i = 0; i < 8; i++)
      vt[4+i] = '{1'b1, 4'h0, 6'(16 + 4*i), 32'h0, 1'b1, 32'h0};
    vt[12] = '{1'b1, 4'h0, 6'd60, 32'h0, 1'b1, 32'h0};
    vt[13] = '{1'b1, 4'b0101, 6'd24, 32'hAABBCCDD, 1'b0, 32'h0};
    vt[14] = '{1'b1, 4'h0, 6'd24, 32'h0, 1'b1, 32'h00BB00DD};
    vt[15] = '{1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 32'h0};

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].en, vt[i].we, vt[i].addr, vt[i].din);
      tick();
      chk($sformatf("vec%0d_valid", i), {31'b0, mif.valid},
          {31'b0, vt[i].exp_valid});
      if (vt[i].exp_valid)
        chk($sformatf("vec%0d_dout", i), mif.dout, vt[i].exp_dout);
    end
    idle();
    chk("be_cfg2", cfg_regs[95:64], 32'h00BB00DD);

    wr(6'd0, 4'h1, 32'h3);
    chk("cmd_start_pulse", {31'b0, cmd_start}, 32'd1);
    chk("cmd_busy_on",     {31'b0, cmd_busy},  32'd1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("cmd_start_low%0d", i), {31'b0, cmd_start}, 32'd0);
      chk($sformatf("cmd_busy_hold%0d", i), {31'b0, cmd_busy}, 32'd1);
    end
    cmd_done_valid = 1'b1;
    cmd_done       = 1'b1;
    tick();
    idle();
    chk("cmd_busy_off", {31'b0, cmd_busy}, 32'd0);
    chk("cmd_irq_on",   {31'b0, irq},      32'd1);
    rd_chk("cmd_status", 6'd4, 32'h2);
    rd_chk("cmd_cnt",    6'd8, 32'd10);
    wr(6'd4, 4'h1, 32'h2);
    chk("cmd_irq_clr", {31'b0, irq}, 32'd0);

    wr(6'd0, 4'h1, 32'h1);
    chk("err_start", {31'b0, cmd_start}, 32'd1);
    tick();
    wr(6'd0, 4'h1, 32'h1);
    chk("rej_no_start", {31'b0, cmd_start}, 32'd0);
    chk("rej_busy",     {31'b0, cmd_busy},  32'd1);
    rd_chk("rej_status", 6'd4, 32'h9);
    cmd_done_valid = 1'b1;
    cmd_done       = 1'b0;
    tick();
    idle();
    rd_chk("err_status", 6'd4, 32'hC);
    chk("err_irq_gated", {31'b0, irq}, 32'd0);
    wr(6'd0, 4'h1, 32'h1);
    chk("restart", {31'b0, cmd_start}, 32'd1);
    rd_chk("restart_status", 6'd4, 32'h9);

    drive(1'b1, 4'h1, 6'd0, 32'h1);
    cmd_done_valid = 1'b1;
    cmd_done       = 1'b1;
    tick();
    idle();
    chk("sim_no_start", {31'b0, cmd_start}, 32'd0);
    chk("sim_idle",     {31'b0, cmd_busy},  32'd0);
    rd_chk("sim_status", 6'd4, 32'hA);
    wr(6'd0, 4'h1, 32'h3);
    chk("sim2_start", {31'b0, cmd_start}, 32'd1);
    tick();
    drive(1'b1, 4'h1, 6'd4, 32'h2);
    cmd_done_valid = 1'b1;
    cmd_done       = 1'b1;
    tick();
    idle();
    chk("w1c_set_irq", {31'b0, irq}, 32'd1);
    rd_chk("w1c_set_status", 6'd4, 32'hA);

    wr(6'd0, 4'h1, 32'h1);
    tick();
    tick();
    chk("mid_busy", {31'b0, cmd_busy}, 32'd1);
    arstz_aq = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, cmd_busy}, 32'd0);
    #2;
    arstz_aq = 1'b1;
    tick();
    rd_chk("mid_status", 6'd4, 32'h0);
    rd_chk("mid_cnt",    6'd8, 32'h0);
    cmd_done_valid = 1'b1;
    cmd_done       = 1'b1;
    tick();
    idle();
    chk("stray_busy", {31'b0, cmd_busy}, 32'd0);
    rd_chk("stray_status", 6'd4, 32'h0);

    arstz_aq = 1'b0;
    #2;
    arstz_aq = 1'b1;
    m_reset();
    tick();
    m_edge = 0;
    for (int c = 0; c < 600; c++) begin
      r_en   = ($urandom_range(0, 3) != 0);
      r_we   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      r_addr = ($urandom_range(0, 1) == 0) ?
               6'({$urandom_range(0, 2), 2'($urandom)}) : 6'($urandom);
      r_din  = $urandom;
      r_dv   = ($urandom_range(0, 5) == 0);
      r_dn   = 1'($urandom);
      drive(r_en, r_we, r_addr, r_din);
      cmd_done_valid = r_dv;
      cmd_done       = r_dn;
      m_step(r_en, r_we, r_addr, r_din, r_dv, r_dn,
             e_valid, e_dout, e_start);
      tick();
      for (int i = 0; i < 8; i++) e_cfg[32*i +: 32] = m_cfg[i];
      chk($sformatf("rnd%0d_start", c), {31'b0, cmd_start},
          {31'b0, e_start});
      chk($sformatf("rnd%0d_busy", c), {31'b0, cmd_busy},
          {31'b0, m_busy});
      chk($sformatf("rnd%0d_irq", c), {31'b0, irq},
          {31'b0, m_irq_en & (m_done | m_err)});
      chk($sformatf("rnd%0d_valid", c), {31'b0, mif.valid},
          {31'b0, e_valid});
      if (e_valid) chk($sformatf("rnd%0d_dout", c), mif.dout, e_dout);
      n_tests++;
      if (cfg_regs !== e_cfg) begin
        n_fail++;
        $display("FAIL rnd%0d_cfg: got %h expected %h", c, cfg_regs, e_cfg);
      end
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
